// File: rtl/cmd_interpreter.sv
// Byte-oriented debug command interpreter: decodes UART opcodes and drives core reset, gated clock and memory.
// Optional macro CMD_INTERP_TIMEOUT_EN adds a payload-reception timeout that answers 8'hEE.
module cmd_interpreter #(
    parameter int         CLK_FREQ     = 25000000,
    parameter int         ADDR_WIDTH   = 32,
    parameter int         DATA_WIDTH   = 32,
    parameter int         RESET_CYCLES = 16,
    parameter logic [7:0] ID_BYTE      = 8'h50
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_clear,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  core_reset,
    output logic                  core_clk_en,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int         ABYTES       = ADDR_WIDTH / 8;
    localparam int         DBYTES       = DATA_WIDTH / 8;
    localparam int         PW           = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [7:0] ABYTES_B     = 8'(ABYTES);
    localparam logic [7:0] DBYTES_B     = 8'(DBYTES);
    localparam logic [7:0] PAY_WRITE_B  = 8'(ABYTES + DBYTES);
    localparam logic [7:0] RESET_LAST   = 8'(RESET_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(CLK_FREQ / 1000 - 1);

    localparam logic [7:0] OP_RESET = 8'h01;
    localparam logic [7:0] OP_CLOCK = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h04;
    localparam logic [7:0] OP_PING  = 8'h05;
    localparam logic [7:0] RESP_ACK = 8'hAA;
    localparam logic [7:0] RESP_NAK = 8'hEE;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DECODE     = 3'd1,
        RX_PAYLOAD = 3'd2,
        EXEC       = 3'd3,
        MEM_WAIT   = 3'd4,
        TX_RESP    = 3'd5
    } state_t;

    state_t                state_r, state_s;
    logic [7:0]            opcode_r, opcode_s;
    logic [PW-1:0]         shift_r, shift_s;
    logic [7:0]            byte_cnt_r, byte_cnt_s;
    logic [7:0]            reset_cnt_r, reset_cnt_s;
    logic [15:0]           clk_cnt_r, clk_cnt_s;
    logic [DATA_WIDTH-1:0] resp_r, resp_s;
    logic [7:0]            resp_cnt_r, resp_cnt_s;
    logic                  rx_clear_r, rx_clear_s;
    logic                  tx_valid_r, tx_valid_s;
    logic                  core_reset_r, core_reset_s;
    logic                  core_clk_en_r, core_clk_en_s;
    logic                  mem_req_r, mem_req_s;
    logic                  mem_we_r, mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_r, mem_wdata_s;
    logic                  accept_s;
`ifdef CMD_INTERP_TIMEOUT_EN
    logic [31:0]           to_cnt_r, to_cnt_s;
`else
    logic [31:0]           timeout_unused_s;
    assign timeout_unused_s = TIMEOUT_LAST;
`endif

    // Single-byte response placed in the MSB lane so it is the first byte shifted out.
    function automatic logic [DATA_WIDTH-1:0] load_byte(input logic [7:0] b);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        r[DATA_WIDTH-1 -: 8] = b;
        return r;
    endfunction

    // A level-valid UART still shows the byte while rx_clear is in flight, so that cycle is skipped.
    assign accept_s = rx_valid && !rx_clear_r &&
                      ((state_r == IDLE) || (state_r == RX_PAYLOAD));

    assign rx_clear    = rx_clear_r;
    assign tx_valid    = tx_valid_r;
    assign tx_data     = resp_r[DATA_WIDTH-1 -: 8];
    assign core_reset  = core_reset_r;
    assign core_clk_en = core_clk_en_r;
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;

    // Next-state and next-output computation for the command FSM.
    always_comb begin
        state_s       = state_r;
        opcode_s      = opcode_r;
        shift_s       = shift_r;
        byte_cnt_s    = byte_cnt_r;
        reset_cnt_s   = reset_cnt_r;
        clk_cnt_s     = clk_cnt_r;
        resp_s        = resp_r;
        resp_cnt_s    = resp_cnt_r;
        rx_clear_s    = accept_s;
        tx_valid_s    = tx_valid_r;
        core_reset_s  = core_reset_r;
        core_clk_en_s = core_clk_en_r;
        mem_req_s     = mem_req_r;
        mem_we_s      = mem_we_r;
        mem_addr_s    = mem_addr_r;
        mem_wdata_s   = mem_wdata_r;
`ifdef CMD_INTERP_TIMEOUT_EN
        to_cnt_s      = to_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    opcode_s = rx_data;
                    state_s  = DECODE;
                end else begin
                    state_s = IDLE;
                end
            end
            DECODE: begin
                shift_s = '0;
`ifdef CMD_INTERP_TIMEOUT_EN
                to_cnt_s = 32'd0;
`endif
                case (opcode_r)
                    OP_CLOCK: begin
                        byte_cnt_s = 8'd1;
                        state_s    = RX_PAYLOAD;
                    end
                    OP_READ: begin
                        byte_cnt_s = ABYTES_B;
                        state_s    = RX_PAYLOAD;
                    end
                    OP_WRITE: begin
                        byte_cnt_s = PAY_WRITE_B;
                        state_s    = RX_PAYLOAD;
                    end
                    OP_RESET: begin
                        core_reset_s = 1'b1;
                        reset_cnt_s  = RESET_LAST;
                        state_s      = EXEC;
                    end
                    default: begin
                        state_s = EXEC;
                    end
                endcase
            end
            RX_PAYLOAD: begin
                if (accept_s) begin
                    shift_s    = {shift_r[PW-9:0], rx_data};
                    byte_cnt_s = byte_cnt_r - 8'd1;
`ifdef CMD_INTERP_TIMEOUT_EN
                    to_cnt_s   = 32'd0;
`endif
                    if (byte_cnt_r == 8'd1) begin
                        state_s = EXEC;
                        // Gated clock starts on EXEC entry so exactly N cycles are enabled.
                        if ((opcode_r == OP_CLOCK) && (rx_data != 8'd0)) begin
                            core_clk_en_s = 1'b1;
                            clk_cnt_s     = {8'h00, rx_data} - 16'd1;
                        end else begin
                            core_clk_en_s = 1'b0;
                        end
                    end else begin
                        state_s = RX_PAYLOAD;
                    end
                end else begin
`ifdef CMD_INTERP_TIMEOUT_EN
                    if (to_cnt_r == TIMEOUT_LAST) begin
                        to_cnt_s   = 32'd0;
                        resp_s     = load_byte(RESP_NAK);
                        resp_cnt_s = 8'd1;
                        tx_valid_s = 1'b1;
                        state_s    = TX_RESP;
                    end else begin
                        to_cnt_s = to_cnt_r + 32'd1;
                    end
`else
                    state_s = RX_PAYLOAD;
`endif
                end
            end
            EXEC: begin
                case (opcode_r)
                    OP_RESET: begin
                        if (reset_cnt_r == 8'd0) begin
                            core_reset_s = 1'b0;
                            resp_s       = load_byte(RESP_ACK);
                            resp_cnt_s   = 8'd1;
                            tx_valid_s   = 1'b1;
                            state_s      = TX_RESP;
                        end else begin
                            reset_cnt_s = reset_cnt_r - 8'd1;
                        end
                    end
                    OP_CLOCK: begin
                        if (core_clk_en_r && (clk_cnt_r != 16'd0)) begin
                            clk_cnt_s = clk_cnt_r - 16'd1;
                        end else begin
                            core_clk_en_s = 1'b0;
                            resp_s        = load_byte(RESP_ACK);
                            resp_cnt_s    = 8'd1;
                            tx_valid_s    = 1'b1;
                            state_s       = TX_RESP;
                        end
                    end
                    OP_READ: begin
                        mem_req_s  = 1'b1;
                        mem_we_s   = 1'b0;
                        mem_addr_s = shift_r[ADDR_WIDTH-1:0];
                        state_s    = MEM_WAIT;
                    end
                    OP_WRITE: begin
                        mem_req_s   = 1'b1;
                        mem_we_s    = 1'b1;
                        mem_addr_s  = shift_r[PW-1 -: ADDR_WIDTH];
                        mem_wdata_s = shift_r[DATA_WIDTH-1:0];
                        state_s     = MEM_WAIT;
                    end
                    OP_PING: begin
                        resp_s     = load_byte(ID_BYTE);
                        resp_cnt_s = 8'd1;
                        tx_valid_s = 1'b1;
                        state_s    = TX_RESP;
                    end
                    default: begin
                        resp_s     = load_byte(RESP_NAK);
                        resp_cnt_s = 8'd1;
                        tx_valid_s = 1'b1;
                        state_s    = TX_RESP;
                    end
                endcase
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    mem_req_s  = 1'b0;
                    mem_we_s   = 1'b0;
                    tx_valid_s = 1'b1;
                    state_s    = TX_RESP;
                    if (opcode_r == OP_READ) begin
                        resp_s     = mem_rdata;
                        resp_cnt_s = DBYTES_B;
                    end else begin
                        resp_s     = load_byte(RESP_ACK);
                        resp_cnt_s = 8'd1;
                    end
                end else begin
                    state_s = MEM_WAIT;
                end
            end
            TX_RESP: begin
                if (tx_valid_r && tx_ready) begin
                    if (resp_cnt_r == 8'd1) begin
                        tx_valid_s = 1'b0;
                        resp_s     = '0;
                        resp_cnt_s = 8'd0;
                        state_s    = IDLE;
                    end else begin
                        resp_s     = resp_r << 8'd8;
                        resp_cnt_s = resp_cnt_r - 8'd1;
                    end
                end else begin
                    state_s = TX_RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any command silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            opcode_r      <= 8'd0;
            shift_r       <= '0;
            byte_cnt_r    <= 8'd0;
            reset_cnt_r   <= 8'd0;
            clk_cnt_r     <= 16'd0;
            resp_r        <= '0;
            resp_cnt_r    <= 8'd0;
            rx_clear_r    <= 1'b0;
            tx_valid_r    <= 1'b0;
            core_reset_r  <= 1'b0;
            core_clk_en_r <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
`ifdef CMD_INTERP_TIMEOUT_EN
            to_cnt_r      <= 32'd0;
`endif
        end else begin
            state_r       <= state_s;
            opcode_r      <= opcode_s;
            shift_r       <= shift_s;
            byte_cnt_r    <= byte_cnt_s;
            reset_cnt_r   <= reset_cnt_s;
            clk_cnt_r     <= clk_cnt_s;
            resp_r        <= resp_s;
            resp_cnt_r    <= resp_cnt_s;
            rx_clear_r    <= rx_clear_s;
            tx_valid_r    <= tx_valid_s;
            core_reset_r  <= core_reset_s;
            core_clk_en_r <= core_clk_en_s;
            mem_req_r     <= mem_req_s;
            mem_we_r      <= mem_we_s;
            mem_addr_r    <= mem_addr_s;
            mem_wdata_r   <= mem_wdata_s;
`ifdef CMD_INTERP_TIMEOUT_EN
            to_cnt_r      <= to_cnt_s;
`endif
        end
    end

endmodule

// File: tb/tb_cmd_interpreter.sv
// Directed self-checking bench for cmd_interpreter; inputs driven and outputs sampled on the falling edge.
// The timeout scenario is compiled only with CMD_INTERP_TIMEOUT_EN.
module tb_cmd_interpreter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_clear;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        core_reset;
    logic        core_clk_en;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_bad = 0;
    int en_cycles = 0;
    int en_rises = 0;
    int rst_cycles = 0;
    int clr_count = 0;
    logic en_prev = 1'b0;

    always #5 clk = ~clk;

    cmd_interpreter dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_clear(rx_clear),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .core_reset(core_reset),
        .core_clk_en(core_clk_en), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Event monitors for pulse widths and rx_clear counts.
    always @(posedge clk) begin
        if (core_clk_en) en_cycles <= en_cycles + 1;
        if (core_clk_en && !en_prev) en_rises <= en_rises + 1;
        en_prev <= core_clk_en;
        if (core_reset) rst_cycles <= rst_cycles + 1;
        if (rx_clear) clr_count <= clr_count + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic recv_byte(output logic [7:0] b, output logic ok);
        int i;
        ok = 1'b0;
        b = 8'h00;
        i = 0;
        while (!ok && i < 1000) begin
            if (tx_valid) begin
                b = tx_data;
                ok = 1'b1;
            end else begin
                @(negedge clk);
                i++;
            end
        end
        if (ok) begin
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
    endtask

    task automatic wait_mem_req(output logic ok);
        int i;
        ok = 1'b0;
        i = 0;
        while (!ok && i < 100) begin
            if (mem_req) ok = 1'b1;
            else begin
                @(negedge clk);
                i++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rx_clear, tx_valid, tx_data, core_reset, core_clk_en, mem_req, mem_we, mem_addr, mem_wdata} !== 78'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got tx_valid=%b tx_data=%h mem_req=%b addr=%h required all zero",
                     tx_valid, tx_data, mem_req, mem_addr);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ping();
        int c0;
        logic [7:0] b;
        logic ok;
        c0 = clr_count;
        rx_data = 8'h05;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        n_cmp++;
        if (rx_clear !== 1'b1) begin n_bad++; $display("FAIL ping_rx_clear: got %b required 1", rx_clear); end
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL ping_early1: tx_valid got %b required 0", tx_valid); end
        @(negedge clk);
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL ping_early2: tx_valid got %b required 0", tx_valid); end
        @(negedge clk);
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h50) begin
            n_bad++; $display("FAIL ping_latency: got valid=%b data=%h required valid=1 data=50", tx_valid, tx_data);
        end
        n_cmp++;
        if ({core_reset, core_clk_en, mem_req} !== 3'b000) begin
            n_bad++; $display("FAIL ping_side: got %b required 000", {core_reset, core_clk_en, mem_req});
        end
        recv_byte(b, ok);
        n_cmp++;
        if (!ok || b !== 8'h50) begin n_bad++; $display("FAIL ping_resp: got %h ok=%b required 50", b, ok); end
        n_cmp++;
        if (clr_count - c0 != 1) begin n_bad++; $display("FAIL ping_clr_count: got %0d required 1", clr_count - c0); end
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL ping_done: tx_valid got %b required 0", tx_valid); end
    endtask

    task automatic test_clock(input logic [7:0] n);
        int e0, r0, exp_rises;
        logic [7:0] b;
        logic ok;
        e0 = en_cycles;
        r0 = en_rises;
        exp_rises = (n != 8'd0) ? 1 : 0;
        send_byte(8'h02);
        send_byte(n);
        recv_byte(b, ok);
        n_cmp++;
        if (en_cycles - e0 != int'(n)) begin
            n_bad++; $display("FAIL clock_pulses_%0d: got %0d required %0d", n, en_cycles - e0, n);
        end
        n_cmp++;
        if (en_rises - r0 != exp_rises) begin
            n_bad++; $display("FAIL clock_runs_%0d: got %0d required %0d", n, en_rises - r0, exp_rises);
        end
        n_cmp++;
        if (!ok || b !== 8'hAA) begin n_bad++; $display("FAIL clock_resp_%0d: got %h ok=%b required aa", n, b, ok); end
    endtask

    task automatic test_core_reset();
        int r0;
        logic [7:0] b;
        logic ok;
        r0 = rst_cycles;
        send_byte(8'h01);
        recv_byte(b, ok);
        n_cmp++;
        if (rst_cycles - r0 != 16) begin n_bad++; $display("FAIL core_reset_len: got %0d required 16", rst_cycles - r0); end
        n_cmp++;
        if (!ok || b !== 8'hAA || core_reset !== 1'b0) begin
            n_bad++; $display("FAIL core_reset_resp: got %h ok=%b core_reset=%b required aa/0", b, ok, core_reset);
        end
    endtask

    task automatic test_write();
        logic [7:0] bytes_q [9] = '{8'h04, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic [7:0] b;
        logic ok;
        foreach (bytes_q[i]) send_byte(bytes_q[i]);
        wait_mem_req(ok);
        n_cmp++;
        if (!ok || mem_we !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL write_req: got ok=%b we=%b addr=%h wdata=%h required 1/1/00001000/deadbeef",
                              ok, mem_we, mem_addr, mem_wdata);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1 || tx_valid !== 1'b0) begin
            n_bad++; $display("FAIL write_hold: got req=%b tx_valid=%b required 1/0", mem_req, tx_valid);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b0) begin n_bad++; $display("FAIL write_req_drop: got %b required 0", mem_req); end
        recv_byte(b, ok);
        n_cmp++;
        if (!ok || b !== 8'hAA) begin n_bad++; $display("FAIL write_resp: got %h ok=%b required aa", b, ok); end
    endtask

    task automatic test_read();
        logic [7:0] cmd_q [5] = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00};
        logic [7:0] exp_q [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        logic [7:0] b;
        logic ok;
        foreach (cmd_q[i]) send_byte(cmd_q[i]);
        wait_mem_req(ok);
        n_cmp++;
        if (!ok || mem_we !== 1'b0 || mem_addr !== 32'h0000_1000) begin
            n_bad++; $display("FAIL read_req: got ok=%b we=%b addr=%h required 1/0/00001000", ok, mem_we, mem_addr);
        end
        repeat (2) @(negedge clk);
        mem_rdata = 32'h1234_5678;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (tx_valid !== 1'b1 || tx_data !== 8'h56) begin
                        n_bad++; $display("FAIL read_stall_%0d: got valid=%b data=%h required 1/56", k, tx_valid, tx_data);
                    end
                end
            end
            recv_byte(b, ok);
            n_cmp++;
            if (!ok || b !== exp_q[i]) begin
                n_bad++; $display("FAIL read_byte_%0d: got %h ok=%b required %h", i, b, ok, exp_q[i]);
            end
        end
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL read_end: tx_valid got %b required 0", tx_valid); end
    endtask

    task automatic test_nak();
        logic [7:0] ops [3] = '{8'h7F, 8'h00, 8'hFF};
        logic [7:0] b;
        logic ok;
        foreach (ops[i]) begin
            send_byte(ops[i]);
            recv_byte(b, ok);
            n_cmp++;
            if (!ok || b !== 8'hEE) begin n_bad++; $display("FAIL nak_%h: got %h ok=%b required ee", ops[i], b, ok); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] cmd_q [5] = '{8'h03, 8'h00, 8'h00, 8'h20, 8'h00};
        logic [7:0] b;
        logic ok;
        int c0;
        foreach (cmd_q[i]) send_byte(cmd_q[i]);
        wait_mem_req(ok);
        c0 = clr_count;
        rx_data = 8'h55;
        rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!ok || mem_req !== 1'b1 || clr_count != c0) begin
            n_bad++; $display("FAIL memwait_ignore_rx: got req=%b clears=%0d required 1/0", mem_req, clr_count - c0);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rx_clear, tx_valid, tx_data, core_reset, core_clk_en, mem_req, mem_we, mem_addr, mem_wdata} !== 78'd0) begin
            n_bad++; $display("FAIL midreset_outputs: got req=%b we=%b addr=%h required all zero", mem_req, mem_we, mem_addr);
        end
        reset = 1'b0;
        tx_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid) ok = 1'b1;
        end
        tx_ready = 1'b0;
        n_cmp++;
        if (ok !== 1'b0) begin n_bad++; $display("FAIL midreset_noresp: tx_valid seen=%b required 0", ok); end
        send_byte(8'h05);
        recv_byte(b, ok);
        n_cmp++;
        if (!ok || b !== 8'h50) begin n_bad++; $display("FAIL midreset_ping: got %h ok=%b required 50", b, ok); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic ok;
        int c0;
        send_byte(8'h05);
        c0 = clr_count;
        rx_data = 8'h05;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (clr_count != c0 || tx_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_hold: got clears=%0d tx_valid=%b required 0/1", clr_count - c0, tx_valid);
        end
        recv_byte(b, ok);
        n_cmp++;
        if (!ok || b !== 8'h50) begin n_bad++; $display("FAIL b2b_first: got %h ok=%b required 50", b, ok); end
        @(negedge clk);
        n_cmp++;
        if (rx_clear !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: rx_clear got %b required 1", rx_clear); end
        rx_valid = 1'b0;
        recv_byte(b, ok);
        n_cmp++;
        if (!ok || b !== 8'h50) begin n_bad++; $display("FAIL b2b_second: got %h ok=%b required 50", b, ok); end
    endtask

`ifdef CMD_INTERP_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] b;
        logic ok;
        int cyc;
        send_byte(8'h04);
        send_byte(8'h00);
        cyc = 0;
        while (!tx_valid && cyc < 30000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc < 24900 || cyc > 25100) begin
            n_bad++; $display("FAIL timeout_len: got %0d cycles required about 25000", cyc);
        end
        recv_byte(b, ok);
        n_cmp++;
        if (!ok || b !== 8'hEE) begin n_bad++; $display("FAIL timeout_resp: got %h ok=%b required ee", b, ok); end
        send_byte(8'h05);
        recv_byte(b, ok);
        n_cmp++;
        if (!ok || b !== 8'h50) begin n_bad++; $display("FAIL timeout_ping: got %h ok=%b required 50", b, ok); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tx_ready = 1'b0;
        mem_rdata = 32'h0;
        mem_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_ping();
        test_clock(8'd3);
        test_clock(8'd0);
        test_clock(8'd255);
        test_core_reset();
        test_write();
        test_read();
        test_nak();
        test_reset_mid();
        test_back_to_back();
`ifdef CMD_INTERP_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
